// File: rtl/chess_clock_display_pkg.sv
// Shared constants for the chess clock display: field slices of the packed
// M:SS countdown, the power-on time shown before the first snapshot, and glyphs.
package chess_clock_display_pkg;

    localparam int MIN_HI  = 9;
    localparam int MIN_LO  = 7;
    localparam int TENS_HI = 6;
    localparam int TENS_LO = 4;
    localparam int ONES_HI = 3;
    localparam int ONES_LO = 0;

    localparam logic [9:0] RESET_TIME = 10'h2B9;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;

    typedef enum logic [1:0] {
        FIELD_NONE,
        FIELD_MIN,
        FIELD_TENS,
        FIELD_ONES
    } field_e;

endpackage

// File: rtl/chess_clock_display_if.sv
// Timer-to-display bundle: two packed countdowns and the move bit in,
// multiplexed active-low anode/segment/decimal-point drive out.
interface chess_clock_display_if;
    logic [9:0] countdown_white;
    logic [9:0] countdown_black;
    logic       turn;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output countdown_white, countdown_black, turn,
        input  an, seg, dp
    );

    modport slave (
        input  countdown_white, countdown_black, turn,
        output an, seg, dp
    );
endinterface

// File: rtl/chess_clock_display_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment glyph; codes 10-15 show 'E'.
module bcd_to_7seg
    import chess_clock_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = GLYPH_E;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = GLYPH_E;
        endcase
    end

endmodule

// File: rtl/chess_clock_display.sv
// Eight-digit multiplexed display of both chess clocks (White left, Black right)
// with a per-frame snapshot, flag dashes and a blinking decimal point for the side to move.
module chess_clock_display #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLINK_HZ   = 2
) (
    input logic                  clk,
    input logic                  rst,
    chess_clock_display_if.slave disp
);
    import chess_clock_display_pkg::*;

    localparam int DIV = CLK_HZ / (REFRESH_HZ * 8);
    localparam int HB  = CLK_HZ / (2 * BLINK_HZ);
    localparam int RW  = $clog2(DIV);
    localparam int HW  = $clog2(HB);
    localparam logic [RW-1:0] DIV_LAST = RW'(DIV - 1);
    localparam logic [HW-1:0] HB_LAST  = HW'(HB - 1);

    logic [RW-1:0] refresh_cnt;
    logic [HW-1:0] blink_cnt;
    logic          blink_phase;
    logic [2:0]    idx;
    logic          scanning;
    logic [9:0]    shadow_white;
    logic [9:0]    shadow_black;
    logic          shadow_turn;
    logic          digit_tick;

    field_e        field;
    logic [9:0]    side_time;
    logic          side_flag;
    logic          side_turn;
    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic [7:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;
    logic [7:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    assign digit_tick = (refresh_cnt == DIV_LAST);

    // Shadows are only reloaded as the scan returns to digit 0, so a frame never mixes two times.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt  <= '0;
            idx          <= '0;
            scanning     <= 1'b0;
            shadow_white <= RESET_TIME;
            shadow_black <= RESET_TIME;
            shadow_turn  <= 1'b0;
        end else begin
            refresh_cnt <= digit_tick ? '0 : refresh_cnt + RW'(1);
            if (digit_tick) begin
                idx      <= idx + 3'd1;
                scanning <= 1'b1;
                if (idx == 3'd7) begin
                    shadow_white <= disp.countdown_white;
                    shadow_black <= disp.countdown_black;
                    shadow_turn  <= disp.turn;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == HB_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + HW'(1);
        end
    end

    // idx[2] selects White (7..4) or Black (3..0); idx[1:0] == 3 is the blank gap.
    always_comb begin
        field     = FIELD_NONE;
        side_time = idx[2] ? shadow_white : shadow_black;
        side_turn = idx[2] ? ~shadow_turn : shadow_turn;
        side_flag = (side_time == 10'h000);
        nibble    = 4'd0;
        case (idx[1:0])
            2'd2:    field = FIELD_MIN;
            2'd1:    field = FIELD_TENS;
            2'd0:    field = FIELD_ONES;
            default: field = FIELD_NONE;
        endcase
        case (field)
            FIELD_MIN:  nibble = {1'b0, side_time[MIN_HI:MIN_LO]};
            FIELD_TENS: nibble = {1'b0, side_time[TENS_HI:TENS_LO]};
            FIELD_ONES: nibble = side_time[ONES_HI:ONES_LO];
            default:    nibble = 4'd0;
        endcase
    end

    bcd_to_7seg u_dec (
        .digit (nibble),
        .seg   (glyph)
    );

    always_comb begin
        an_next  = ~(8'b1 << idx);
        seg_next = glyph;
        if (field == FIELD_NONE) begin
            seg_next = GLYPH_BLANK;
        end else if (side_flag) begin
            seg_next = GLYPH_DASH;
        end else if (field == FIELD_TENS && nibble > 4'd5) begin
            seg_next = GLYPH_E;
        end
        dp_next = ~(field == FIELD_MIN && side_turn && !side_flag && blink_phase);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= 8'hFF;
            seg_q <= GLYPH_BLANK;
            dp_q  <= 1'b1;
        end else if (scanning) begin
            an_q  <= an_next;
            seg_q <= seg_next;
            dp_q  <= dp_next;
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule

// File: tb/tb_chess_clock_display.sv
// Directed bench for chess_clock_display with DIV=10, HB=20 (plus a HB=40 copy
// so both blink phases are seen on the move digit).
module tb_chess_clock_display;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GB = 7'h7F;
    localparam logic [6:0] GD = 7'b0111111;
    localparam logic [6:0] GE = 7'b0000110;

    typedef struct packed {
        logic [9:0]      w;
        logic [9:0]      b;
        logic            t;
        logic [7:0][6:0] g;
        logic [7:0]      dpm;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[8];

    chess_clock_display_if bus ();
    chess_clock_display_if bus2 ();

    chess_clock_display #(.CLK_HZ(800), .REFRESH_HZ(10), .BLINK_HZ(20)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .disp (bus)
    );

    chess_clock_display #(.CLK_HZ(800), .REFRESH_HZ(10), .BLINK_HZ(10)) u_dut_slow_blink (
        .clk  (clk),
        .rst  (rst),
        .disp (bus2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected end of sequence");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic [9:0] w, input logic [9:0] b, input logic t);
        bus.countdown_white  = w;
        bus.countdown_black  = b;
        bus.turn             = t;
        bus2.countdown_white = w;
        bus2.countdown_black = b;
        bus2.turn            = t;
    endtask

    task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected anode from the edge count k: the index after k-1 edges is ((k-1)/10)%8,
    // scanning starts on the 10th edge and the outputs lag it by one edge.
    task automatic check_cycle(input string tag, input logic [7:0][6:0] g, input logic [7:0] dpm);
        int k;
        int i;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        logic e_dp2;
        k = cyc;
        if (k <= 10) begin
            e_an  = 8'hFF;
            e_seg = GB;
            e_dp  = 1'b1;
            e_dp2 = 1'b1;
        end else begin
            i     = ((k - 1) / 10) % 8;
            e_an  = ~(8'b1 << i);
            e_seg = g[i];
            e_dp  = ~(dpm[i] && ((((k - 1) / 20) % 2) == 1));
            e_dp2 = ~(dpm[i] && ((((k - 1) / 40) % 2) == 1));
        end
        compare($sformatf("%s an", tag), bus.an, e_an);
        compare($sformatf("%s seg", tag), {1'b0, bus.seg}, {1'b0, e_seg});
        compare($sformatf("%s dp", tag), {7'd0, bus.dp}, {7'd0, e_dp});
        compare($sformatf("%s dp_hb40", tag), {7'd0, bus2.dp}, {7'd0, e_dp2});
    endtask

    // Advance to the negedge right after a snapshot edge (edge count a multiple of 80).
    task automatic sync_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((cyc % 80) != 0 && n < 200);
        n_checks++;
        if ((cyc % 80) != 0) begin
            n_fail++;
            $display("FAIL sync: got cycle %0d, expected a frame boundary", cyc);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0][6:0] g, input logic [7:0] dpm, input int ncyc);
        for (int j = 0; j < ncyc; j++) begin
            @(negedge clk);
            check_cycle(tag, g, dpm);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{w: 10'h2B9, b: 10'h2B9, t: 1'b0, g: {GB, G5, G3, G9, GB, G5, G3, G9}, dpm: 8'h40};
        vecs[1] = '{w: 10'h2B9, b: 10'h2B9, t: 1'b1, g: {GB, G5, G3, G9, GB, G5, G3, G9}, dpm: 8'h04};
        vecs[2] = '{w: 10'h2B9, b: 10'h000, t: 1'b1, g: {GB, G5, G3, G9, GB, GD, GD, GD}, dpm: 8'h00};
        vecs[3] = '{w: 10'h07A, b: 10'h2B9, t: 1'b0, g: {GB, G0, GE, GE, GB, G5, G3, G9}, dpm: 8'h40};
        vecs[4] = '{w: 10'h3D9, b: 10'h0F0, t: 1'b1, g: {GB, G7, G5, G9, GB, G1, GE, G0}, dpm: 8'h04};
        vecs[5] = '{w: 10'h000, b: 10'h2B9, t: 1'b0, g: {GB, GD, GD, GD, GB, G5, G3, G9}, dpm: 8'h00};
        vecs[6] = '{w: 10'h000, b: 10'h000, t: 1'b1, g: {GB, GD, GD, GD, GB, GD, GD, GD}, dpm: 8'h00};
        vecs[7] = '{w: 10'h0BF, b: 10'h2C4, t: 1'b0, g: {GB, G1, G3, GE, GB, G5, G4, G4}, dpm: 8'h40};

        rst = 1'b1;
        set_in(10'h2B9, 10'h2B9, 1'b0);
        repeat (3) @(negedge clk);
        compare("reset an", bus.an, 8'hFF);
        compare("reset seg", {1'b0, bus.seg}, {1'b0, GB});
        compare("reset dp", {7'd0, bus.dp}, 8'd1);
        rst = 1'b0;

        // First frame after reset comes from the reset-time shadows.
        run_frame("boot", vecs[0].g, vecs[0].dpm, 80);

        for (int v = 0; v < 8; v++) begin
            set_in(vecs[v].w, vecs[v].b, vecs[v].t);
            sync_frame();
            run_frame($sformatf("vec%0d", v), vecs[v].g, vecs[v].dpm, 80);
        end

        // Input change while idx3 is showing: current frame keeps 5:39, next shows 5:38.
        set_in(10'h2B9, 10'h2B9, 1'b0);
        sync_frame();
        run_frame("midframe_old", vecs[0].g, vecs[0].dpm, 35);
        set_in(10'h2B8, 10'h2B9, 1'b0);
        run_frame("midframe_hold", vecs[0].g, vecs[0].dpm, 45);
        run_frame("midframe_new", {GB, G5, G3, G8, GB, G5, G3, G9}, 8'h40, 80);

        // Reset while idx4 is showing: outputs clear at once, then 5:39 from reset shadows.
        set_in(10'h2B9, 10'h2B9, 1'b0);
        sync_frame();
        run_frame("prerst", vecs[0].g, vecs[0].dpm, 45);
        set_in(10'h0F0, 10'h000, 1'b1);
        rst = 1'b1;
        #1;
        compare("midrst an", bus.an, 8'hFF);
        compare("midrst seg", {1'b0, bus.seg}, {1'b0, GB});
        compare("midrst dp", {7'd0, bus.dp}, 8'd1);
        @(negedge clk);
        compare("midrst hold an", bus.an, 8'hFF);
        compare("midrst hold seg", {1'b0, bus.seg}, {1'b0, GB});
        rst = 1'b0;
        run_frame("postrst", vecs[0].g, vecs[0].dpm, 80);
        run_frame("postrst_snap", {GB, G1, GE, G0, GB, GD, GD, GD}, 8'h00, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chess_clock_display.md
Name: chess_clock_display

Overview:
- Downstream consumer of the chess timer's two packed countdowns; drives the board's 8-digit common-anode 7-segment display.
- Left half (digits 6..4) shows White as M SS; right half (digits 2..0) shows Black as M SS.
- Blinks the decimal point of the side to move.
- Shows "---" for a side whose clock has reached 0:00.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- REFRESH_HZ, 1000, full-frame refresh rate in Hz. Digit period DIV = CLK_HZ/(REFRESH_HZ*8), must be >= 2.
- BLINK_HZ, 2, decimal-point blink rate in Hz. Half period HB = CLK_HZ/(2*BLINK_HZ), must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- countdown_white  in  10  {min[2:0], sec_tens[2:0], sec_ones[3:0]}, BCD, White clock.
- countdown_black  in  10  same packing, Black clock.
- turn  in  1  side to move: 0 = White, 1 = Black (timer's move bit 13).
- an  out  8  digit anodes, active-low, an[7] = leftmost.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset values:
  - an = 8'hFF, seg = 7'h7F, dp = 1.
  - Refresh counter, blink counter and digit index = 0; blink phase = 0.
  - Shadow registers = 10'h2B9 (5:39), turn shadow = 0.
- Refresh counter counts 0..DIV-1, then wraps to 0. The wrap cycle is the digit tick.
- Digit index (3 bits) increments on each digit tick, 7 wraps to 0.
- Frame snapshot: when the digit index wraps 7 -> 0, both countdowns and turn are captured into shadow registers in the same cycle. Display content comes only from the shadows, so no tearing within a frame.
- Digit map:
  - idx7 blank, idx6 White min, idx5 White sec_tens, idx4 White sec_ones.
  - idx3 blank, idx2 Black min, idx1 Black sec_tens, idx0 Black sec_ones.
- Output timing: an/seg/dp are registered, one cycle after the index changes. Exactly one an bit is low at any time after the first tick; all anodes stay high until then.
- Decode: 0-9 use standard glyphs.
- Invalid field (sec_tens > 5 or sec_ones > 9): that digit shows 'E' (seg = 7'b0000110).
- Flag: a side whose shadow equals 10'h000 shows '-' (seg = 7'b0111111) on all three of its digits. Flag takes priority over invalid.
- Blank digits: seg = 7'h7F, dp = 1.
- Blink: a counter of 0..HB-1 toggles the blink phase on wrap. The dp on the min digit of the side in the turn shadow is low when the blink phase = 1, else high. All other dp are high. A flagged side's dp is always high.
- turn changes mid-frame: no visible effect until the next snapshot.
- rst mid-frame: all state returns to reset values immediately. Scanning resumes DIV cycles after deassertion.

Decomposition:
- Shared package holds:
  - Field slice constants: MIN = [9:7], TENS = [6:4], ONES = [3:0].
  - Reset-time constant 10'h2B9.
  - Glyph constants: GLYPH_BLANK, GLYPH_DASH, GLYPH_E.
- One sub-module, bcd_to_7seg: combinational 4-bit to 7-bit active-low decoder, 'E' for 10-15.
- Counters, snapshot, mux and flag/blink logic live in the top module.

Test Plan (CLK_HZ=800, REFRESH_HZ=10, BLINK_HZ=20, so DIV=10, HB=20):
- Reset then run 80 cycles with white=10'h2B9, black=10'h2B9 -> idx6/5/4 and idx2/1/0 show 5,3,9 with only one an bit low each digit period; an[7], an[3] show 7'h7F.
- Change white to 10'h2B8 at idx3 -> display keeps 9 until the idx 7->0 wrap, then shows 8 from the next frame.
- turn=1 held -> dp low only while an[2] is low and blink phase = 1; dp toggles every 20 cycles; never low on an[6].
- black=10'h000 -> idx2..0 show 7'b0111111 and dp stays high on an[2] even with turn=1.
- white=10'h07A (tens=7, ones=10) -> idx5 and idx4 show 7'b0000110, idx6 shows 0.
- Assert rst mid-frame at idx4 -> next cycle an=8'hFF, seg=7'h7F, dp=1; first anode asserts 10 cycles after deassertion and shows 5:39.
